myproject_dense_accum_16s_25s: RTL and testbench
================================================

MYPROJECT_DENSE_ACCUM_16S_25S -- requirements
Module: myproject_dense_accum_16s_25s

Interface
REQ-001 SHALL provide parameter N_IN, default 16: number of 25-bit products summed per output neuron, legal range 1..1024.
REQ-002 SHALL provide parameter ACC_W, default 32: accumulator width; must satisfy ACC_W >= 26 + ceil(log2(N_IN)).
REQ-003 SHALL provide parameter SHIFT, default 7: arithmetic right shift from accumulator scale to output scale, legal range 0..ACC_W-16.
REQ-004 SHALL have port ap_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port ap_rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port prod_data, input, 25 bits: signed product from the upstream 16s x 9s multiplier.
REQ-007 SHALL have port prod_valid, input, 1 bit: prod_data is valid.
REQ-008 SHALL have port prod_ready, output, 1 bit: block accepts prod_data this cycle.
REQ-009 SHALL have port bias_in, input, 16 bits: signed bias in accumulator scale, sampled with the first product of each neuron.
REQ-010 SHALL have port out_data, output, 16 bits: signed, saturated neuron result.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.

Function
REQ-013 SHALL transfer a product only when prod_valid and prod_ready are both high on a rising edge; the same rule applies to out_valid and out_ready.
REQ-014 SHALL implement states IDLE, ACCUM and OUT; prod_ready is high in IDLE and ACCUM and low in OUT; out_valid is high only in OUT.
REQ-015 On a transfer in IDLE, SHALL load acc = sext(bias_in) + sext(prod_data) and count = 1, then go to OUT if N_IN==1, else to ACCUM.
REQ-016 On a transfer in ACCUM, SHALL set acc += sext(prod_data) and increment count; the transfer that makes count == N_IN SHALL move the state to OUT.
REQ-017 SHALL compute the output as y = acc >>> SHIFT (arithmetic shift, floor rounding), then saturate to [-32768, 32767]; out_data SHALL be registered.
REQ-018 SHALL assert out_valid on the cycle after the N_IN-th product transfer (latency 1) and hold out_data and out_valid stable until out_ready is high.
REQ-019 On an out_ready transfer in OUT, SHALL return to IDLE and clear count; the next product SHALL be accepted no earlier than the following cycle.
REQ-020 Accumulator arithmetic SHALL wrap modulo 2^ACC_W; with REQ-002 satisfied, no wrap occurs for legal inputs.
REQ-021 prod_valid deasserted mid-neuron SHALL stall accumulation with acc and count unchanged; gaps of any length are legal.

Reset
REQ-022 While ap_rst is high at a rising edge, SHALL set state=IDLE, acc=0, count=0, out_data=0 and out_valid=0; prod_ready SHALL be 1 from the first cycle after reset.
REQ-023 Reset asserted mid-neuron or in OUT SHALL discard the partial or pending result without emitting it.
REQ-024 Reset SHALL take priority over any simultaneous handshake transfer.

Configuration
REQ-025 With macro MYPROJECT_ACCUM_RELU_EN defined, SHALL apply ReLU after saturation (negative results become 0); without it, signed saturated results SHALL pass through unchanged.

Verification
REQ-026 N_IN=4, SHIFT=7, bias 0, products 128, 256, -128, 384 -> out_data=5 with out_valid high exactly one cycle after the 4th transfer.
REQ-027 N_IN=4, four products of 8388607, bias 0 -> acc=33554428, out_data=32767 (positive saturation).
REQ-028 N_IN=4, four products of -16777216 -> out_data=-32768 without the macro, 0 with MYPROJECT_ACCUM_RELU_EN defined.
REQ-029 Single neuron summing to -1 (bias 0, products -1, 0, 0, 0) -> out_data=-1 (floor), or 0 with ReLU enabled.
REQ-030 out_ready held low 5 cycles in OUT -> out_data stable, prod_ready=0 throughout; accepted on the 6th cycle, IDLE on the next cycle.
REQ-031 ap_rst pulsed after 2 of 4 products -> out_valid stays 0, no output emitted; a following full neuron with bias 256 and products 0, 0, 0, 0 -> out_data=2.

Source files
------------

// File: rtl/myproject_dense_accum_16s_25s.sv
// Dense-layer neuron accumulator: bias plus N_IN signed 25-bit products, shifted and saturated to 16 bits.
// Optional ReLU on the result when MYPROJECT_ACCUM_RELU_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first product of a neuron (bias sampled with it)
// ACCUM | summing the remaining products
// OUT   | result held on out_data until downstream accepts it
module myproject_dense_accum_16s_25s #(
  parameter int N_IN  = 16,
  parameter int ACC_W = 32,
  parameter int SHIFT = 7
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [24:0] prod_data,
  input  logic        prod_valid,
  output logic        prod_ready,
  input  logic [15:0] bias_in,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN + 1) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;

  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [15:0]              y_sat;
  logic [15:0]              y_final;
  logic                     last;

  always_comb begin
    bias_ext = {{(ACC_W-16){bias_in[15]}}, bias_in};
    prod_ext = {{(ACC_W-25){prod_data[24]}}, prod_data};
    // the first product of a neuron starts from the bias instead of the stale accumulator
    acc_sum  = ((state == IDLE) ? bias_ext : acc) + prod_ext;
    shifted  = acc_sum >>> SHIFT;
    if (shifted > SAT_MAX)      y_sat = 16'h7fff;
    else if (shifted < SAT_MIN) y_sat = 16'h8000;
    else                        y_sat = shifted[15:0];
`ifdef MYPROJECT_ACCUM_RELU_EN
    y_final = y_sat[15] ? 16'h0000 : y_sat;
`else
    y_final = y_sat;
`endif
    last = (state == IDLE) ? (N_IN == 1) : (count == CNT_W'(N_IN - 1));
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      prod_ready <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (prod_valid) begin
            acc   <= acc_sum;
            count <= (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
            if (last) begin
              state      <= OUT;
              out_data   <= y_final;
              out_valid  <= 1'b1;
              prod_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state      <= IDLE;
            count      <= '0;
            out_valid  <= 1'b0;
            prod_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          out_valid  <= 1'b0;
          prod_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_dense_accum_16s_25s.sv
// Directed self-checking bench for myproject_dense_accum_16s_25s with N_IN=4, SHIFT=7.
module tb_myproject_dense_accum_16s_25s;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [24:0] prod_data = '0;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [15:0] bias_in = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_dense_accum_16s_25s #(.N_IN(4), .ACC_W(32), .SHIFT(7)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .bias_in(bias_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // Present one product and hold it until the transfer edge; returns #1 after that edge.
  task automatic send(input int d, input int b);
    int n;
    n = 0;
    prod_data  = 25'(d);
    bias_in    = 16'(b);
    prod_valid = 1'b1;
    while (prod_ready !== 1'b1 && n < 20) begin
      @(posedge ap_clk); #1; n++;
    end
    if (n >= 20) chk("prod_ready_timeout", 0, 1);
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
  endtask

  task automatic neuron(input string tag, input int b, input int p0, input int p1,
                        input int p2, input int p3, input int gap, input int exp);
    send(p0, b);
    repeat (gap) @(posedge ap_clk);
    #0 send(p1, 0);
    repeat (gap) @(posedge ap_clk);
    #0 send(p2, 0);
    chk({tag, "_no_early_valid"}, int'(out_valid), 0);
    send(p3, 0);
    chk({tag, "_valid_latency1"}, int'(out_valid), 1);
    chk({tag, "_ready_low_in_out"}, int'(prod_ready), 0);
    chk({tag, "_data"}, sdata(), exp);
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_after_accept"}, int'(out_valid), 0);
    chk({tag, "_ready_after_accept"}, int'(prod_ready), 1);
  endtask

  int exp_neg_sat, exp_floor, held;

  initial begin
`ifdef MYPROJECT_ACCUM_RELU_EN
    exp_neg_sat = 0;
    exp_floor   = 0;
`else
    exp_neg_sat = -32768;
    exp_floor   = -1;
`endif
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", sdata(), 0);
    chk("reset_prod_ready", int'(prod_ready), 1);

    // 128+256-128+384 = 640; 640>>>7 = 5
    neuron("basic", 0, 128, 256, -128, 384, 0, 5);
    // stalls between products must not disturb the sum
    neuron("gaps", 0, 128, 256, -128, 384, 3, 5);
    // 4*8388607 = 33554428; >>>7 = 262143 -> saturates
    neuron("pos_sat", 0, 8388607, 8388607, 8388607, 8388607, 0, 32767);
    // 4*-16777216 = -67108864; >>>7 = -524288 -> saturates low
    neuron("neg_sat", 0, -16777216, -16777216, -16777216, -16777216, 0, exp_neg_sat);
    // -1 >>> 7 floors to -1
    neuron("floor", 0, -1, 0, 0, 0, 0, exp_floor);
    // bias only: 1000 >>> 7 = 7
    neuron("bias", 1000, 0, 0, 0, 0, 0, 7);

    // backpressure: hold out_ready low 5 cycles
    send(640, 0); send(0, 0); send(0, 0); send(0, 0);
    held = sdata();
    chk("bp_data_initial", held, 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1;
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_data_stable", sdata(), 5);
      chk("bp_ready_low", int'(prod_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_valid", int'(out_valid), 0);
    chk("bp_idle_ready", int'(prod_ready), 1);

    // reset after 2 of 4 products, with a product offered during reset
    send(12800, 0); send(12800, 0);
    prod_data  = 25'(1000);
    bias_in    = 16'(1000);
    prod_valid = 1'b1;
    ap_rst     = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst     = 1'b0;
    prod_valid = 1'b0;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_ready", int'(prod_ready), 1);
    repeat (3) begin
      @(posedge ap_clk); #1;
      chk("rst_mid_no_emit", int'(out_valid), 0);
    end
    // 256 >>> 7 = 2
    neuron("after_rst", 256, 0, 0, 0, 0, 0, 2);

    // reset while a result is pending in OUT
    send(640, 0); send(0, 0); send(0, 0); send(0, 0);
    chk("rst_out_pending", int'(out_valid), 1);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", sdata(), 0);
    chk("rst_out_ready", int'(prod_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
